mouse_click_ctl: RTL and testbench



---
 rtl/mouse_pkg.sv | 30 +++
 rtl/axis_div.sv | 56 +++++
 rtl/mouse_click_ctl.sv | 176 +++++++++++++++++
 tb/tb_mouse_click_ctl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared types and default widths for the mouse click controller.
//   DEF_POS_W : default pixel coordinate width
//   DEF_IDX_W : default cell index / board_size width
//   DEF_FS_W  : default field_size (pixels per cell) width
//   cmd_t     : command encoding driven on cmd_type
//   state_t   : controller sequencing states
// -----------------------------------------------------------------------------
package mouse_pkg;

    localparam int DEF_POS_W = 12;
    localparam int DEF_IDX_W = 5;
    localparam int DEF_FS_W  = 6;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_DIG   = 2'b01,
        CMD_FLAG  = 2'b10,
        CMD_CHORD = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_CHECK,
        ST_ISSUE
    } state_t;

endpackage

// File: rtl/axis_div.sv
// -----------------------------------------------------------------------------
// axis_div
// Repeated-subtraction divider for one board axis: idx = offset / field_size,
// capped at board_size so the iteration count stays bounded.
//   clk, rst     : clock, synchronous active-high reset
//   start        : load offset, clear idx (one cycle before iteration begins)
//   offset       : non-negative pixel offset from the board edge
//   field_size   : cell pitch in pixels
//   board_size   : cells per side
//   done         : quotient final (remainder below pitch, or cap reached)
//   idx          : current quotient
//   out_of_range : idx reached board_size, i.e. offset lies past the board
// -----------------------------------------------------------------------------
module axis_div
    import mouse_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int FS_W  = DEF_FS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [POS_W-1:0] offset,
    input  logic [FS_W-1:0]  field_size,
    input  logic [IDX_W-1:0] board_size,
    output logic             done,
    output logic [IDX_W-1:0] idx,
    output logic             out_of_range
);

    logic [POS_W-1:0] rem;
    logic [POS_W-1:0] fs_ext;

    assign fs_ext       = POS_W'(field_size);
    // The cap is tested before the remainder so an offset of exactly
    // board_size*field_size is still reported as off-board.
    assign out_of_range = (idx == board_size);
    assign done         = out_of_range || (rem < fs_ext);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            idx <= '0;
        end else if (start) begin
            rem <= offset;
            idx <= '0;
        end else if (!done) begin
            rem <= rem - fs_ext;
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mouse_click_ctl.sv
// -----------------------------------------------------------------------------
// mouse_click_ctl
// Turns mouse button edges plus cursor position into one board-addressed
// command (DIG / FLAG / CHORD) delivered over a valid/ready handshake.
// Optional feature macro: MOUSE_CHORD_EN (chord detection; off by default).
//   clk, rst               : clock, synchronous active-high reset
//   left, right            : button levels, synchronous to clk
//   mouse_xpos, mouse_ypos : cursor position in pixels
//   board_xpos, board_ypos : board top-left corner in pixels
//   board_size             : cells per side (1..30)
//   field_size             : cell pitch in pixels
//   cmd_valid, cmd_ready   : command handshake
//   cmd_type               : DIG=01, FLAG=10, CHORD=11
//   cmd_col, cmd_row       : target cell
//   miss                   : one-cycle pulse, press discarded
//   busy                   : controller not idle
// -----------------------------------------------------------------------------
module mouse_click_ctl
    import mouse_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int FS_W  = DEF_FS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    input  logic [POS_W-1:0] board_xpos,
    input  logic [POS_W-1:0] board_ypos,
    input  logic [IDX_W-1:0] board_size,
    input  logic [FS_W-1:0]  field_size,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_type,
    output logic [IDX_W-1:0] cmd_col,
    output logic [IDX_W-1:0] cmd_row,
    output logic             miss,
    output logic             busy
);

    state_t           state, state_next;
    cmd_t             type_q, type_next, cmd_type_q;
    logic             left_q, right_q;
    logic             left_rise, right_rise;
    logic [POS_W:0]   off_x, off_y;
    logic             off_neg;
    logic             start, miss_next, load_cmd;
    logic             x_done, y_done, x_oor, y_oor;
    logic [IDX_W-1:0] x_idx, y_idx;

    assign left_rise  = left  & ~left_q;
    assign right_rise = right & ~right_q;

    // One extra bit keeps the sign so a cursor left of / above the board
    // is caught before dividing.
    assign off_x   = {1'b0, mouse_xpos} - {1'b0, board_xpos};
    assign off_y   = {1'b0, mouse_ypos} - {1'b0, board_ypos};
    assign off_neg = off_x[POS_W] | off_y[POS_W];

    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        type_next = CMD_FLAG;
`ifdef MOUSE_CHORD_EN
        // Covers both simultaneous rises and a rise while the other is held.
        if ((left_rise && right) || (right_rise && left)) begin
            type_next = CMD_CHORD;
        end else if (left_rise) begin
            type_next = CMD_DIG;
        end
`else
        if (left_rise) begin
            type_next = CMD_DIG;
        end
`endif
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        miss_next  = 1'b0;
        load_cmd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (left_rise || right_rise) begin
                    if (off_neg || (field_size == '0)) begin
                        miss_next = 1'b1;
                    end else begin
                        start      = 1'b1;
                        state_next = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (x_done && y_done) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (x_oor || y_oor) begin
                    miss_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    load_cmd   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Button history updates every cycle, busy or not, so a held button
    // never produces a late rise once the controller frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            miss       <= 1'b0;
            type_q     <= CMD_NONE;
            cmd_type_q <= CMD_NONE;
            cmd_col    <= '0;
            cmd_row    <= '0;
        end else begin
            state   <= state_next;
            left_q  <= left;
            right_q <= right;
            miss    <= miss_next;
            if (start) begin
                type_q <= type_next;
            end
            if (load_cmd) begin
                cmd_type_q <= type_q;
                cmd_col    <= x_idx;
                cmd_row    <= y_idx;
            end
        end
    end

    assign cmd_valid = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign cmd_type  = cmd_type_q;

    axis_div #(.POS_W(POS_W), .IDX_W(IDX_W), .FS_W(FS_W)) u_div_x (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .offset       (off_x[POS_W-1:0]),
        .field_size   (field_size),
        .board_size   (board_size),
        .done         (x_done),
        .idx          (x_idx),
        .out_of_range (x_oor)
    );

    axis_div #(.POS_W(POS_W), .IDX_W(IDX_W), .FS_W(FS_W)) u_div_y (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .offset       (off_y[POS_W-1:0]),
        .field_size   (field_size),
        .board_size   (board_size),
        .done         (y_done),
        .idx          (y_idx),
        .out_of_range (y_oor)
    );

endmodule

// File: tb/tb_mouse_click_ctl.sv
// -----------------------------------------------------------------------------
// tb_mouse_click_ctl
// Directed bench for mouse_click_ctl on a board at (100,50), pitch 32, 8x8.
// Cycle N is the cycle in which a button is first seen high; after k calls
// of step() the bench observes cycle N+k.
// -----------------------------------------------------------------------------
module tb_mouse_click_ctl;
    import mouse_pkg::*;

    localparam int POS_W = 12;
    localparam int IDX_W = 5;
    localparam int FS_W  = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             left, right;
    logic [POS_W-1:0] mouse_xpos, mouse_ypos, board_xpos, board_ypos;
    logic [IDX_W-1:0] board_size;
    logic [FS_W-1:0]  field_size;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_type;
    logic [IDX_W-1:0] cmd_col, cmd_row;
    logic             miss, busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MOUSE_CHORD_EN
    localparam logic [1:0] EXP_BOTH = 2'b11;
`else
    localparam logic [1:0] EXP_BOTH = 2'b01;
`endif

    always #5 clk = ~clk;

    mouse_click_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .left       (left),
        .right      (right),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .board_xpos (board_xpos),
        .board_ypos (board_ypos),
        .board_size (board_size),
        .field_size (field_size),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_col    (cmd_col),
        .cmd_row    (cmd_row),
        .miss       (miss),
        .busy       (busy)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_buttons();
        left  = 1'b0;
        right = 1'b0;
        step(2);
    endtask

    task automatic click(input logic l, input logic r, input int x, input int y);
        mouse_xpos = POS_W'(x);
        mouse_ypos = POS_W'(y);
        left       = l;
        right      = r;
    endtask

    // Returns the number of cycles after the click at which cmd_valid first
    // rose, or -1 if it never did within the bound.
    task automatic wait_valid(input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (cmd_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", cmd_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (miss !== 1'b0) begin n_bad++; $display("FAIL reset_miss: got %0b expected 0", miss); end
        n_cmp++; if ({cmd_type, cmd_col, cmd_row} !== 12'h000) begin n_bad++; $display("FAIL reset_payload: got type=%0d col=%0d row=%0d expected 0/0/0", cmd_type, cmd_col, cmd_row); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_dig_basic();
        int lat;
        release_buttons();
        click(1'b1, 1'b0, 201, 114);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL dig_latency: got %0d expected 6", lat); end
        n_cmp++; if (cmd_type !== 2'b01) begin n_bad++; $display("FAIL dig_type: got %0d expected 1", cmd_type); end
        n_cmp++; if (cmd_col !== 5'd3 || cmd_row !== 5'd2) begin n_bad++; $display("FAIL dig_cell: got col=%0d row=%0d expected 3/2", cmd_col, cmd_row); end
        n_cmp++; if (miss !== 1'b0) begin n_bad++; $display("FAIL dig_miss: got %0b expected 0", miss); end
        step();
        n_cmp++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL dig_one_cycle: got valid=%0b busy=%0b expected 0/0", cmd_valid, busy); end
    endtask

    task automatic test_miss_negative();
        int seen_valid;
        release_buttons();
        click(1'b0, 1'b1, 99, 60);
        step();
        n_cmp++; if (miss !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL neg_miss: got miss=%0b busy=%0b expected 1/0", miss, busy); end
        step();
        n_cmp++; if (miss !== 1'b0) begin n_bad++; $display("FAIL neg_miss_pulse: got %0b expected 0", miss); end
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_valid === 1'b1) seen_valid++;
        end
        n_cmp++; if (seen_valid !== 0) begin n_bad++; $display("FAIL neg_no_cmd: got %0d valid cycles expected 0", seen_valid); end
    endtask

    task automatic test_miss_range();
        int miss_at, seen_valid;
        release_buttons();
        click(1'b0, 1'b1, 356, 60);
        miss_at    = -1;
        seen_valid = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (miss === 1'b1 && miss_at < 0) miss_at = i;
            if (cmd_valid === 1'b1) seen_valid++;
        end
        n_cmp++; if (miss_at !== 11) begin n_bad++; $display("FAIL range_miss_cycle: got %0d expected 11", miss_at); end
        n_cmp++; if (seen_valid !== 0) begin n_bad++; $display("FAIL range_no_cmd: got %0d valid cycles expected 0", seen_valid); end
    endtask

    task automatic test_stall();
        int lat, seen_valid;
        release_buttons();
        cmd_ready = 1'b0;
        click(1'b1, 1'b0, 201, 114);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL stall_latency: got %0d expected 6", lat); end
        for (int i = 1; i <= 10; i++) begin
            if (i == 2 || i == 6) left = 1'b0;
            if (i == 4 || i == 7) left = 1'b1;
            step();
            n_cmp++;
            if (cmd_valid !== 1'b1 || cmd_type !== 2'b01 || cmd_col !== 5'd3 || cmd_row !== 5'd2) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got valid=%0b type=%0d col=%0d row=%0d expected 1/1/3/2",
                         i, cmd_valid, cmd_type, cmd_col, cmd_row);
            end
        end
        cmd_ready = 1'b1;
        step();
        n_cmp++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_transfer: got valid=%0b busy=%0b expected 0/0", cmd_valid, busy); end
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_valid === 1'b1 || busy === 1'b1) seen_valid++;
        end
        n_cmp++; if (seen_valid !== 0) begin n_bad++; $display("FAIL stall_no_retrigger: got %0d active cycles expected 0", seen_valid); end
    endtask

    task automatic test_chord();
        int lat;
        release_buttons();
        click(1'b1, 1'b1, 150, 60);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL chord_latency: got %0d expected 4", lat); end
        n_cmp++; if (cmd_type !== EXP_BOTH) begin n_bad++; $display("FAIL chord_type: got %0d expected %0d", cmd_type, EXP_BOTH); end
        n_cmp++; if (cmd_col !== 5'd1 || cmd_row !== 5'd0) begin n_bad++; $display("FAIL chord_cell: got col=%0d row=%0d expected 1/0", cmd_col, cmd_row); end
        step();
    endtask

    task automatic test_held_other();
        int lat;
        release_buttons();
        click(1'b0, 1'b1, 150, 60);
        wait_valid(20, lat);
        n_cmp++; if (cmd_type !== 2'b10 || lat !== 4) begin n_bad++; $display("FAIL held_flag: got type=%0d lat=%0d expected 2/4", cmd_type, lat); end
        step(2);
        left = 1'b1;
        wait_valid(20, lat);
        n_cmp++; if (cmd_type !== EXP_BOTH || lat !== 4) begin n_bad++; $display("FAIL held_second: got type=%0d lat=%0d expected %0d/4", cmd_type, lat, EXP_BOTH); end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        release_buttons();
        click(1'b1, 1'b0, 356, 60);
        step(3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %0b expected 1", busy); end
        rst  = 1'b1;
        left = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_abort: got busy=%0b valid=%0b expected 0/0", busy, cmd_valid); end
        rst = 1'b0;
        step(2);
        click(1'b1, 1'b0, 201, 114);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 6 || cmd_col !== 5'd3 || cmd_row !== 5'd2) begin n_bad++; $display("FAIL rstmid_after: got lat=%0d col=%0d row=%0d expected 6/3/2", lat, cmd_col, cmd_row); end
        step();
    endtask

    task automatic test_fs_zero();
        release_buttons();
        field_size = '0;
        click(1'b1, 1'b0, 201, 114);
        step();
        n_cmp++; if (miss !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL fs0_miss: got miss=%0b busy=%0b expected 1/0", miss, busy); end
        step();
        field_size = FS_W'(32);
    endtask

    task automatic test_last_cell();
        int lat;
        release_buttons();
        click(1'b1, 1'b0, 355, 305);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL last_latency: got %0d expected 10", lat); end
        n_cmp++; if (cmd_col !== 5'd7 || cmd_row !== 5'd7 || cmd_type !== 2'b01) begin n_bad++; $display("FAIL last_cell: got col=%0d row=%0d type=%0d expected 7/7/1", cmd_col, cmd_row, cmd_type); end
        step();
    endtask

    initial begin
        left       = 1'b0;
        right      = 1'b0;
        mouse_xpos = '0;
        mouse_ypos = '0;
        board_xpos = POS_W'(100);
        board_ypos = POS_W'(50);
        board_size = IDX_W'(8);
        field_size = FS_W'(32);
        cmd_ready  = 1'b1;
        rst        = 1'b1;

        test_reset();
        test_dig_basic();
        test_miss_negative();
        test_miss_range();
        test_stall();
        test_chord();
        test_held_other();
        test_reset_mid();
        test_fs_zero();
        test_last_cell();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
